// File: rtl/noise_pkg.sv
// noise_pkg: shared types and constants for the noise_acq sequencer.
//   state_e        sequencer state encoding
//   ACQNUM_W       width of sample / read counts
//   DIVNUM_W       width of the sample-clock divider
//   *_CYC_DEF      default phase lengths in clk_sys cycles
//   tmr_load()     reload value for the phase down-counter
package noise_pkg;

  localparam int ACQNUM_W      = 12;
  localparam int DIVNUM_W      = 10;
  localparam int LOAD_CYC_DEF  = 5;
  localparam int ARM_CYC_DEF   = 5;
  localparam int RDRST_CYC_DEF = 5;
  localparam int TMR_W         = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    ACQ,
    RDRST,
    READ,
    DONE
  } state_e;

  // Down-counter runs cyc-1 .. 0, so the phase lasts exactly cyc cycles.
  function automatic logic [TMR_W-1:0] tmr_load(input int cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/noise_acq_seq_if.sv
// noise_acq_seq_if: host / DSP command register side of the sequencer.
//   acq_start, acq_abort      command strobes (host -> sequencer)
//   cfg_acqnum, cfg_divnum    run configuration (host -> sequencer)
//   busy, acq_done, rd_done   status (sequencer -> host)
//   timeout                   sticky watchdog flag (sequencer -> host)
// Modports: master = host side, slave = sequencer side.
interface noise_acq_seq_if;
  import noise_pkg::*;

  logic                acq_start;
  logic                acq_abort;
  logic [ACQNUM_W-1:0] cfg_acqnum;
  logic [DIVNUM_W-1:0] cfg_divnum;
  logic                busy;
  logic                acq_done;
  logic                rd_done;
  logic                timeout;

  modport master (
    output acq_start, acq_abort, cfg_acqnum, cfg_divnum,
    input  busy, acq_done, rd_done, timeout
  );

  modport slave (
    input  acq_start, acq_abort, cfg_acqnum, cfg_divnum,
    output busy, acq_done, rd_done, timeout
  );

endinterface

// File: rtl/noise_acq_seq_edge_sync.sv
// edge_sync: optional 2-flop synchronizer followed by a one-cycle edge detector.
//   clk_sys, n_reset   clock / async active-low reset
//   in_i               input level
//   edge_o             one-cycle pulse on the selected edge
// BYPASS = 1 skips the synchronizer (input already in clk_sys domain).
// FALL   = 1 detects falling edges, otherwise rising edges.
module edge_sync #(
  parameter bit BYPASS = 1'b0,
  parameter bit FALL   = 1'b0
) (
  input  logic clk_sys,
  input  logic n_reset,
  input  logic in_i,
  output logic edge_o
);

  logic lvl;
  logic prev_q;

  if (BYPASS) begin : g_bypass
    assign lvl = in_i;
  end else begin : g_sync
    logic meta_q;
    logic sync_q;
    always_ff @(posedge clk_sys or negedge n_reset) begin
      if (!n_reset) begin
        meta_q <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        meta_q <= in_i;
        sync_q <= meta_q;
      end
    end
    assign lvl = sync_q;
  end

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) prev_q <= 1'b0;
    else          prev_q <= lvl;
  end

  assign edge_o = FALL ? (prev_q & ~lvl) : (lvl & ~prev_q);

endmodule

// File: rtl/noise_acq_seq.sv
// noise_acq_seq: sequencer owning the control inputs of noise_acq.
//   clk_sys, n_reset     clock / async active-low reset
//   host                 command/status interface (slave modport)
//   Noise_acq_clk        sample strobe from noise_acq (clk_sys domain)
//   XRD                  asynchronous DSP read strobe, one sample per fall
//   noise_load, RAM_RDaddr_rst, RAM_WT_EN, RAM_RD_EN   controls to noise_acq
//   n_acqnum, n_divnum   latched run configuration to noise_acq
// Optional macro ACQ_TIMEOUT_EN adds a TMO_W-bit acquisition watchdog;
// without it timeout is tied low and ACQ waits indefinitely.
//
// state | meaning
// IDLE  | waiting for acq_start
// LOAD  | noise_load high for LOAD_CYC cycles
// ARM   | all controls low for ARM_CYC cycles
// ACQ   | RAM_WT_EN high, counting Noise_acq_clk rising edges
// RDRST | RAM_RDaddr_rst high for RDRST_CYC cycles
// READ  | RAM_RD_EN high, counting synchronized XRD falls
// DONE  | issue rd_done, return to IDLE
module noise_acq_seq
  import noise_pkg::*;
#(
  parameter int LOAD_CYC  = LOAD_CYC_DEF,
  parameter int ARM_CYC   = ARM_CYC_DEF,
  parameter int RDRST_CYC = RDRST_CYC_DEF
`ifdef ACQ_TIMEOUT_EN
  , parameter int TMO_W   = 24
`endif
) (
  input  logic                clk_sys,
  input  logic                n_reset,
  noise_acq_seq_if.slave      host,
  input  logic                Noise_acq_clk,
  input  logic                XRD,
  output logic                noise_load,
  output logic                RAM_RDaddr_rst,
  output logic                RAM_WT_EN,
  output logic                RAM_RD_EN,
  output logic [ACQNUM_W-1:0] n_acqnum,
  output logic [DIVNUM_W-1:0] n_divnum
);

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [ACQNUM_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [ACQNUM_W-1:0] acqnum_q, acqnum_d;
  logic [DIVNUM_W-1:0] divnum_q, divnum_d;
  logic                load_q, load_d;
  logic                wt_en_q, wt_en_d;
  logic                rdrst_q, rdrst_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                acq_done_q, acq_done_d;
  logic                rd_done_q, rd_done_d;
  logic                start_ok;
  logic                smp_rise;
  logic                xrd_fall;
`ifdef ACQ_TIMEOUT_EN
  logic [TMO_W-1:0]    wdg_q, wdg_d;
  logic                timeout_q, timeout_d;
`endif

  edge_sync #(.BYPASS(1'b1), .FALL(1'b0)) u_smp_edge (
    .clk_sys (clk_sys),
    .n_reset (n_reset),
    .in_i    (Noise_acq_clk),
    .edge_o  (smp_rise)
  );

  edge_sync #(.BYPASS(1'b0), .FALL(1'b1)) u_xrd_edge (
    .clk_sys (clk_sys),
    .n_reset (n_reset),
    .in_i    (XRD),
    .edge_o  (xrd_fall)
  );

  assign cnt_inc  = cnt_q + ACQNUM_W'(1);
  assign start_ok = host.acq_start && !host.acq_abort && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    acqnum_d   = acqnum_q;
    divnum_d   = divnum_q;
    acq_done_d = 1'b0;
    rd_done_d  = 1'b0;
`ifdef ACQ_TIMEOUT_EN
    wdg_d      = wdg_q;
    timeout_d  = timeout_q;
`endif

    if (start_ok) begin
      acqnum_d = host.cfg_acqnum;
      divnum_d = host.cfg_divnum;
`ifdef ACQ_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
    end

    if (host.acq_abort) begin
      state_d = IDLE;
      tmr_d   = '0;
      cnt_d   = '0;
`ifdef ACQ_TIMEOUT_EN
      wdg_d   = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            cnt_d = '0;
            if (host.cfg_acqnum == '0) begin
              state_d = DONE;
            end else begin
              state_d = LOAD;
              tmr_d   = tmr_load(LOAD_CYC);
            end
          end
        end
        LOAD: begin
          if (tmr_q == '0) begin
            state_d = ARM;
            tmr_d   = tmr_load(ARM_CYC);
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ARM: begin
          if (tmr_q == '0) begin
            state_d = ACQ;
            cnt_d   = '0;
`ifdef ACQ_TIMEOUT_EN
            wdg_d   = '0;
`endif
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        ACQ: begin
`ifdef ACQ_TIMEOUT_EN
          wdg_d = wdg_q + TMO_W'(1);
`endif
          if (smp_rise) begin
            cnt_d = cnt_inc;
`ifdef ACQ_TIMEOUT_EN
            wdg_d = '0;
`endif
            if (cnt_inc == acqnum_q) begin
              state_d    = RDRST;
              tmr_d      = tmr_load(RDRST_CYC);
              cnt_d      = '0;
              acq_done_d = 1'b1;
            end
          end
`ifdef ACQ_TIMEOUT_EN
          else if (wdg_d == {TMO_W{1'b1}}) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            cnt_d     = '0;
          end
`endif
        end
        RDRST: begin
          if (tmr_q == '0) begin
            state_d = READ;
            cnt_d   = '0;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        READ: begin
          if (xrd_fall) begin
            cnt_d = cnt_inc;
            if (cnt_inc == acqnum_q) begin
              state_d = DONE;
              cnt_d   = '0;
            end
          end
        end
        DONE: begin
          state_d   = IDLE;
          rd_done_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // Controls follow the next state so every output is a plain flop.
    load_d  = (state_d == LOAD);
    wt_en_d = (state_d == ACQ);
    rdrst_d = (state_d == RDRST);
    rd_en_d = (state_d == READ);
    // busy also covers the rd_done cycle so a zero-count run is visible.
    busy_d  = (state_d != IDLE) || rd_done_d;
  end

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      cnt_q      <= '0;
      acqnum_q   <= '0;
      divnum_q   <= '0;
      load_q     <= 1'b0;
      wt_en_q    <= 1'b0;
      rdrst_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      acq_done_q <= 1'b0;
      rd_done_q  <= 1'b0;
`ifdef ACQ_TIMEOUT_EN
      wdg_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      acqnum_q   <= acqnum_d;
      divnum_q   <= divnum_d;
      load_q     <= load_d;
      wt_en_q    <= wt_en_d;
      rdrst_q    <= rdrst_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      acq_done_q <= acq_done_d;
      rd_done_q  <= rd_done_d;
`ifdef ACQ_TIMEOUT_EN
      wdg_q      <= wdg_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign noise_load     = load_q;
  assign RAM_RDaddr_rst = rdrst_q;
  assign RAM_WT_EN      = wt_en_q;
  assign RAM_RD_EN      = rd_en_q;
  assign n_acqnum       = acqnum_q;
  assign n_divnum       = divnum_q;
  assign host.busy      = busy_q;
  assign host.acq_done  = acq_done_q;
  assign host.rd_done   = rd_done_q;
`ifdef ACQ_TIMEOUT_EN
  assign host.timeout   = timeout_q;
`else
  assign host.timeout   = 1'b0;
`endif

endmodule
